// File: rtl/riscv_dbg_pkg.sv
// Shared debug types for the simulation watchdog: error causes and FSM states.
package riscv_dbg_pkg;

  typedef enum logic [2:0] {
    NONE     = 3'd0,
    ILLEGAL  = 3'd1,
    MISALIGN = 3'd2,
    STALL    = 3'd3,
    TIMEOUT  = 3'd4
  } err_code_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    ERROR  = 2'd3
  } wd_state_t;

endpackage

// File: rtl/wd_sat_counter.sv
// Saturating up-counter with synchronous clear; at_limit flags the saturated value.
module wd_sat_counter #(
  parameter int WIDTH = 7,
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic at_limit
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  logic [WIDTH-1:0] count;

  assign at_limit = (count == LIM);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !at_limit) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/sim_watchdog.sv
// Simulation watchdog: tracks retirement progress and latches the first error cause
// (illegal, misaligned PC, stall, timeout) or a clean halt.
module sim_watchdog
  import riscv_dbg_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int STALL_LIMIT    = 64,
  parameter int XLEN           = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            retire,
  input  logic [XLEN-1:0] retire_pc,
  input  logic            illegal,
  input  logic            halt,
  output logic            err,
  output logic [2:0]      err_code,
  output logic [XLEN-1:0] err_pc,
  output logic            done,
  output logic [XLEN-1:0] cycle_cnt,
  output logic [XLEN-1:0] retire_cnt
);

  localparam int              STALL_W      = $clog2(STALL_LIMIT + 1);
  localparam logic [XLEN-1:0] TIMEOUT_LAST = XLEN'(TIMEOUT_CYCLES - 1);

  wd_state_t state;
  err_code_t code_q;
  err_code_t detect;
  logic      stall_at_limit;
  logic      running;

  assign running  = (state == RUN);
  assign err      = (state == ERROR);
  assign done     = (state == HALTED);
  assign err_code = code_q;

  // Stall counter only advances while running, so it freezes in the terminal states.
  wd_sat_counter #(
    .WIDTH(STALL_W),
    .LIMIT(STALL_LIMIT)
  ) u_stall (
    .clk     (clk),
    .rst     (rst),
    .clear   (running && retire),
    .enable  (running),
    .at_limit(stall_at_limit)
  );

  always_comb begin
    detect = NONE;
    if (illegal) begin
      detect = ILLEGAL;
    end else if (retire && (retire_pc[1:0] != 2'b00)) begin
      detect = MISALIGN;
    end else if (stall_at_limit) begin
      detect = STALL;
    end else if (cycle_cnt == TIMEOUT_LAST) begin
      detect = TIMEOUT;
    end
  end

  // The cycle that raises an error or halt is still a RUN cycle and is counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      code_q     <= NONE;
      err_pc     <= '0;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      case (state)
        IDLE: state <= RUN;
        RUN: begin
          cycle_cnt <= cycle_cnt + XLEN'(1);
          if (retire) begin
            retire_cnt <= retire_cnt + XLEN'(1);
            err_pc     <= retire_pc;
          end
          if (detect != NONE) begin
            state  <= ERROR;
            code_q <= detect;
          end else if (halt) begin
            state <= HALTED;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sim_watchdog.sv
// Directed scoreboard bench for sim_watchdog: a behavioural model pushes expected
// outputs per driven cycle and each is popped and checked after the clock edge.
module tb_sim_watchdog;
  import riscv_dbg_pkg::*;

  localparam int TO = 20;
  localparam int SL = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        retire = 1'b0;
  logic [31:0] retire_pc = '0;
  logic        illegal = 1'b0;
  logic        halt = 1'b0;
  logic        err;
  logic [2:0]  err_code;
  logic [31:0] err_pc;
  logic        done;
  logic [31:0] cycle_cnt;
  logic [31:0] retire_cnt;

  typedef struct {
    logic        err;
    logic [2:0]  code;
    logic [31:0] pc;
    logic        done;
    logic [31:0] cyc;
    logic [31:0] ret;
  } exp_t;

  exp_t sb[$];

  int tests_run = 0;
  int tests_failed = 0;

  wd_state_t   m_state = IDLE;
  logic [2:0]  m_code = '0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_cyc = '0;
  logic [31:0] m_ret = '0;
  int          m_stall = 0;

  sim_watchdog #(
    .TIMEOUT_CYCLES(TO),
    .STALL_LIMIT   (SL),
    .XLEN          (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .retire    (retire),
    .retire_pc (retire_pc),
    .illegal   (illegal),
    .halt      (halt),
    .err       (err),
    .err_code  (err_code),
    .err_pc    (err_pc),
    .done      (done),
    .cycle_cnt (cycle_cnt),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: observed no finish, expected finish before 200000");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference behaviour for one clock edge given the inputs presented before it.
  task automatic model_step(input logic r_rst, input logic r_retire, input logic [31:0] r_pc,
                            input logic r_ill, input logic r_halt);
    logic [2:0] cause;
    if (r_rst) begin
      m_state = IDLE; m_code = '0; m_pc = '0; m_cyc = '0; m_ret = '0; m_stall = 0;
    end else begin
      case (m_state)
        IDLE: m_state = RUN;
        RUN: begin
          cause = 3'd0;
          if (r_ill) cause = 3'd1;
          else if (r_retire && r_pc[1:0] != 2'b00) cause = 3'd2;
          else if (m_stall == SL) cause = 3'd3;
          else if (m_cyc == 32'(TO - 1)) cause = 3'd4;
          m_cyc = m_cyc + 1;
          if (r_retire) begin
            m_ret = m_ret + 1;
            m_pc = r_pc;
            m_stall = 0;
          end else if (m_stall < SL) begin
            m_stall++;
          end
          if (cause != 3'd0) begin
            m_state = ERROR;
            m_code = cause;
          end else if (r_halt) begin
            m_state = HALTED;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_output();
    exp_t e;
    tests_run++;
    if (sb.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_empty: observed 0 entries expected 1");
      return;
    end
    tests_run--;
    e = sb.pop_front();
    cmp("err", 32'(err), 32'(e.err));
    cmp("err_code", 32'(err_code), 32'(e.code));
    cmp("err_pc", err_pc, e.pc);
    cmp("done", 32'(done), 32'(e.done));
    cmp("cycle_cnt", cycle_cnt, e.cyc);
    cmp("retire_cnt", retire_cnt, e.ret);
  endtask

  task automatic apply_stimulus(input logic r_rst, input logic r_retire, input logic [31:0] r_pc,
                                input logic r_ill, input logic r_halt);
    exp_t e;
    rst = r_rst; retire = r_retire; retire_pc = r_pc; illegal = r_ill; halt = r_halt;
    model_step(r_rst, r_retire, r_pc, r_ill, r_halt);
    e.err  = (m_state == ERROR);
    e.code = m_code;
    e.pc   = m_pc;
    e.done = (m_state == HALTED);
    e.cyc  = m_cyc;
    e.ret  = m_ret;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_output();
  endtask

  // Reset then the IDLE cycle, with junk on the inputs that must be ignored.
  task automatic restart();
    apply_stimulus(1'b1, 1'b1, 32'h3, 1'b1, 1'b1);
    apply_stimulus(1'b0, 1'b1, 32'h1, 1'b1, 1'b1);
  endtask

  initial begin
    // Two reset cycles with noisy inputs, then the IDLE cycle.
    apply_stimulus(1'b1, 1'b1, 32'h2, 1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b1, 32'h2, 1'b1, 1'b1);
    cmp("reset_err", 32'(err), 32'd0);
    cmp("reset_cycle_cnt", cycle_cnt, 32'd0);
    apply_stimulus(1'b0, 1'b1, 32'h5, 1'b1, 1'b0);
    cmp("idle_ignored_err", 32'(err), 32'd0);

    // Clean run: ten aligned retires, halt on the tenth.
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 1'b1, 32'(4 * i), 1'b0, i == 9);
    cmp("halt_done", 32'(done), 32'd1);
    cmp("halt_retire_cnt", retire_cnt, 32'd10);
    cmp("halt_err", 32'(err), 32'd0);
    for (int i = 0; i < 2; i++) apply_stimulus(1'b0, 1'b1, 32'h101, 1'b1, 1'b0);
    cmp("halt_frozen_cycle_cnt", cycle_cnt, 32'd10);

    // Stall: one retire then silence until the stall limit is hit.
    restart();
    apply_stimulus(1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
    for (int i = 0; i < SL; i++) apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    cmp("stall_not_yet", 32'(err), 32'd0);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    cmp("stall_err", 32'(err), 32'd1);
    cmp("stall_code", 32'(err_code), 32'd3);
    cmp("stall_pc", err_pc, 32'h40);

    // Misaligned retire PC.
    restart();
    apply_stimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 32'h4, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 32'h102, 1'b0, 1'b0);
    cmp("misalign_code", 32'(err_code), 32'd2);
    cmp("misalign_pc", err_pc, 32'h102);

    // Illegal and halt together: error wins.
    restart();
    apply_stimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    cmp("illegal_code", 32'(err_code), 32'd1);
    cmp("illegal_done", 32'(done), 32'd0);

    // Timeout with continuous retires, then frozen outputs.
    restart();
    for (int i = 0; i < TO - 1; i++) apply_stimulus(1'b0, 1'b1, 32'(4 * i), 1'b0, 1'b0);
    cmp("timeout_not_yet", 32'(err), 32'd0);
    apply_stimulus(1'b0, 1'b1, 32'(4 * (TO - 1)), 1'b0, 1'b0);
    cmp("timeout_code", 32'(err_code), 32'd4);
    cmp("timeout_pc", err_pc, 32'(4 * (TO - 1)));
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 32'h200, 1'b1, 1'b1);
    cmp("timeout_frozen_retire_cnt", retire_cnt, 32'(TO));

    // Reset out of ERROR: IDLE, then RUN.
    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    cmp("rerst_state_idle", 32'(dut.state), 32'(IDLE));
    cmp("rerst_err_code", 32'(err_code), 32'd0);
    apply_stimulus(1'b0, 1'b1, 32'h8, 1'b0, 1'b0);
    cmp("rerst_state_run", 32'(dut.state), 32'(RUN));
    apply_stimulus(1'b0, 1'b1, 32'h8, 1'b0, 1'b0);
    cmp("rerst_cycle_cnt", cycle_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
